// File: rtl/fir_pkg.sv
// Shared FIR output-path definitions: default widths/depths, sample type and
// the credit-ledger operation decode used by the output buffer.
package fir_pkg;

    localparam int unsigned FIR_DATA_W     = 32;
    localparam int unsigned FIR_DEPTH      = 8;
    localparam int unsigned PIPELINE_DEPTH = 4;

    typedef logic [FIR_DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        CR_HOLD = 2'b00,
        CR_INC  = 2'b01,
        CR_DEC  = 2'b10
    } credit_op_e;

    // A sample entering and one leaving the pipeline in the same cycle cancel out.
    function automatic credit_op_e credit_op(input logic accept, input logic valid);
        credit_op_e op;
        case ({accept, valid})
            2'b10:   op = CR_INC;
            2'b01:   op = CR_DEC;
            default: op = CR_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Circular buffer for FIR output samples. Read data comes straight from the
// registered read pointer, so out-side signals never depend on i_ready.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter  int unsigned DATA_W = FIR_DATA_W,
    parameter  int unsigned DEPTH  = FIR_DEPTH,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_drop
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr_en;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = !w_empty && i_ready;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign w_wr_en = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/fir_output_buffer.sv
// Output buffer behind the FIR pipeline: absorbs non-stallable fir_valid data,
// issues entry credits to the FIR control FSM and flags credit misuse.
module fir_output_buffer
    import fir_pkg::*;
#(
    parameter  int unsigned DATA_W = FIR_DATA_W,
    parameter  int unsigned DEPTH  = FIR_DEPTH,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_accept,
    input  logic              fir_valid,
    input  logic [DATA_W-1:0] fir_data,
    output logic              accept_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  level,
    output logic              overflow_err,
    output logic              credit_err
);

    logic [CNT_W-1:0] r_inflight;
    logic             r_overflow_err;
    logic             r_credit_err;

    logic [CNT_W-1:0] w_count;
    logic             w_drop;
    logic [CNT_W:0]   w_credit_sum;
    credit_op_e       w_op;

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (fir_valid),
        .i_wdata (fir_data),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_rdata (out_data),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    assign w_op = credit_op(sample_accept, fir_valid);

    // Saturating in both directions: a stray fir_valid must not wrap the ledger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case (w_op)
                CR_INC: begin
                    if (r_inflight != '1) begin
                        r_inflight <= r_inflight + CNT_W'(1);
                    end
                end
                CR_DEC: begin
                    if (r_inflight != '0) begin
                        r_inflight <= r_inflight - CNT_W'(1);
                    end
                end
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_err <= 1'b0;
            r_credit_err   <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
            if (fir_valid && (r_inflight == '0)) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign w_credit_sum = {1'b0, w_count} + {1'b0, r_inflight};
    assign accept_ready = (w_credit_sum < (CNT_W + 1)'(DEPTH));
    assign level        = w_count;
    assign overflow_err = r_overflow_err;
    assign credit_err   = r_credit_err;

endmodule

// File: tb/tb_fir_output_buffer.sv
// Directed bench for fir_output_buffer: hand-computed vectors checked with
// immediate assertions one cycle-step at a time.
module tb_fir_output_buffer;
    import fir_pkg::*;

    localparam int unsigned DEPTH = FIR_DEPTH;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_accept = 1'b0;
    logic             fir_valid = 1'b0;
    sample_t          fir_data = '0;
    logic             out_ready = 1'b0;
    logic             accept_ready;
    logic             out_valid;
    sample_t          out_data;
    logic [CNT_W-1:0] level;
    logic             overflow_err;
    logic             credit_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    fir_output_buffer #(
        .DATA_W (FIR_DATA_W),
        .DEPTH  (FIR_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_accept (sample_accept),
        .fir_valid     (fir_valid),
        .fir_data      (fir_data),
        .accept_ready  (accept_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .level         (level),
        .overflow_err  (overflow_err),
        .credit_err    (credit_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic acc, input logic vld, input logic [31:0] d, input logic rdy);
        sample_accept = acc;
        fir_valid     = vld;
        fir_data      = d;
        out_ready     = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_accept_ready", 32'(accept_ready), 32'h1);
        chk("rst_overflow_err", 32'(overflow_err), 32'h0);
        chk("rst_credit_err", 32'(credit_err), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Basic pass-through with three credits issued up front
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            tick();
        end
        chk("pt_accept_ready", 32'(accept_ready), 32'h1);
        drive(1'b0, 1'b1, 32'h11, 1'b1);
        tick();
        chk("pt_valid_1", 32'(out_valid), 32'h1);
        chk("pt_data_1", out_data, 32'h11);
        chk("pt_level_1", 32'(level), 32'h1);
        drive(1'b0, 1'b1, 32'h22, 1'b1);
        tick();
        chk("pt_data_2", out_data, 32'h22);
        chk("pt_level_2", 32'(level), 32'h1);
        drive(1'b0, 1'b1, 32'h33, 1'b1);
        tick();
        chk("pt_data_3", out_data, 32'h33);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("pt_level_end", 32'(level), 32'h0);
        chk("pt_valid_end", 32'(out_valid), 32'h0);
        chk("pt_credit_err", 32'(credit_err), 32'h0);

        // Fill to full with downstream stalled, then overflow, then drain
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 32'(i), 1'b0);
            tick();
            if (i == 1) chk("fill_head_first", out_data, 32'h1);
        end
        chk("fill_level", 32'(level), 32'h8);
        chk("fill_valid", 32'(out_valid), 32'h1);
        chk("fill_head_held", out_data, 32'h1);
        chk("fill_no_ovf", 32'(overflow_err), 32'h0);
        chk("fill_accept_ready", 32'(accept_ready), 32'h0);
        drive(1'b1, 1'b1, 32'h9, 1'b0);
        tick();
        chk("ovf_err", 32'(overflow_err), 32'h1);
        chk("ovf_level", 32'(level), 32'h8);
        chk("ovf_head", out_data, 32'h1);
        chk("ovf_credit_err", 32'(credit_err), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(out_valid), 32'h1);
            chk("drain_data", out_data, 32'(i));
            tick();
        end
        chk("drain_level", 32'(level), 32'h0);
        chk("drain_empty", 32'(out_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow_err), 32'h1);

        // Full with simultaneous push and pop
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'hB0 + 32'(i), 1'b0);
            tick();
        end
        chk("pp_level_full", 32'(level), 32'h8);
        drive(1'b1, 1'b1, 32'hAA, 1'b1);
        tick();
        chk("pp_level", 32'(level), 32'h8);
        chk("pp_no_ovf", 32'(overflow_err), 32'h0);
        chk("pp_head", out_data, 32'hB1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            chk("pp_drain", out_data, 32'hB0 + 32'(i));
            tick();
        end
        chk("pp_last", out_data, 32'hAA);
        tick();
        chk("pp_level_end", 32'(level), 32'h0);

        // Credit exhaustion and return
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            tick();
            if (i == 7) chk("cr_ready_7", 32'(accept_ready), 32'h1);
        end
        chk("cr_ready_8", 32'(accept_ready), 32'h0);
        drive(1'b0, 1'b1, 32'hC1, 1'b1);
        tick();
        chk("cr_ready_push", 32'(accept_ready), 32'h0);
        chk("cr_data", out_data, 32'hC1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("cr_ready_pop", 32'(accept_ready), 32'h1);
        chk("cr_credit_err", 32'(credit_err), 32'h0);

        // fir_valid with nothing in flight
        do_reset();
        drive(1'b0, 1'b1, 32'hD1, 1'b1);
        tick();
        chk("ce_set", 32'(credit_err), 32'h1);
        chk("ce_level", 32'(level), 32'h1);
        chk("ce_data", out_data, 32'hD1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        chk("ce_level_0", 32'(level), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        chk("ce_sticky", 32'(credit_err), 32'h1);

        // Asynchronous reset mid-stream with level 5 and 2 in flight
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            tick();
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 32'h50 + 32'(i), 1'b0);
            tick();
        end
        chk("ar_level_5", 32'(level), 32'h5);
        chk("ar_ready_pre", 32'(accept_ready), 32'h1);
        chk("ar_head", out_data, 32'h51);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_level", 32'(level), 32'h0);
        chk("ar_ready", 32'(accept_ready), 32'h1);
        chk("ar_credit_err", 32'(credit_err), 32'h0);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h5A, 1'b0);
        tick();
        chk("ar_push_level", 32'(level), 32'h1);
        chk("ar_push_valid", 32'(out_valid), 32'h1);
        chk("ar_push_data", out_data, 32'h5A);
        chk("ar_inflight_cleared", 32'(credit_err), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("ar_pop_level", 32'(level), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_output_buffer.md
FIR_OUTPUT_BUFFER -- requirements
Module: fir_output_buffer

Interface
REQ-001 Parameter DATA_W, default 32: FIR output sample width in bits.
REQ-002 Parameter DEPTH, default 8, power of two, >= 2: buffer entries.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sample_accept  input  1  pulse from the FIR control FSM; one sample entered the pipeline.
REQ-006 fir_valid  input  1  FIR pipeline output valid; cannot be back-pressured.
REQ-007 fir_data  input  DATA_W  FIR output sample, qualified by fir_valid.
REQ-008 accept_ready  output  1  credit to the FIR control FSM in_ready; high means one more sample may enter.
REQ-009 out_valid  output  1  downstream valid.
REQ-010 out_data  output  DATA_W  downstream data, qualified by out_valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 level  output  $clog2(DEPTH+1)  current stored entry count.
REQ-013 overflow_err  output  1  sticky; push attempted while full without a same-cycle pop.
REQ-014 credit_err  output  1  sticky; fir_valid seen with zero samples in flight.

Function
REQ-015 Storage: DEPTH-entry circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0; count of $clog2(DEPTH+1) bits.
REQ-016 Push when fir_valid=1; the entry is written at wr_ptr and becomes visible on out_data the following cycle (1-cycle latency).
REQ-017 Pop when out_valid & out_ready; rd_ptr advances.
REQ-018 out_valid = (count != 0); out_data = mem[rd_ptr]; both driven from registered state only, no combinational path from out_ready.
REQ-019 Data stays stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop: count unchanged; allowed when full (no overflow_err), and when count=1.
REQ-021 Empty with fir_valid=1 and out_ready=1: push only; out_valid rises next cycle.
REQ-022 Push while full without pop: data dropped, pointers and count unchanged, overflow_err set.
REQ-023 inflight counter, $clog2(DEPTH+1) bits: +1 on sample_accept, -1 on fir_valid, unchanged when both occur.
REQ-024 fir_valid with inflight=0: credit_err set, inflight stays 0, push still occurs per REQ-016/022.
REQ-025 accept_ready = (count + inflight) < DEPTH, computed from registered count and inflight only.
REQ-026 level = count.
REQ-027 Under correct credit use (upstream honours accept_ready), overflow_err never sets.
REQ-028 Sticky errors clear only on reset.

Reset
REQ-029 While rst_n=0: pointers, count, inflight = 0; out_valid=0; accept_ready=1 (DEPTH>0); level=0; overflow_err=0; credit_err=0.
REQ-030 Reset asserted mid-operation discards all stored and in-flight samples immediately, without waiting for a clock edge; buffer memory contents need not be cleared.
REQ-031 First push is accepted on the first posedge after rst_n deasserts.

Structure
REQ-032 The shared package fir_pkg holds DATA_W and DEPTH defaults, the PIPELINE_DEPTH constant (4), and the sample_t typedef (logic [DATA_W-1:0]).
REQ-033 Storage and pointer logic go in one sub-module, fir_sync_fifo. Credit/inflight tracking and error flags stay in fir_output_buffer.

Verification
REQ-034 Reset, then 3 fir_valid pushes of 0x11, 0x22, 0x33 with out_ready=1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its push; level returns to 0.
REQ-035 out_ready=0, 8 pushes 0x1..0x8 -> level=8, out_valid=1, out_data=0x1 held; 9th push -> overflow_err=1, level=8; then drain -> outputs 0x1..0x8 in order.
REQ-036 Full (level=8) with simultaneous push 0xAA and pop -> level stays 8, overflow_err=0, 0xAA emerges last.
REQ-037 8 sample_accept pulses with no fir_valid -> accept_ready=0 after the 8th; one fir_valid plus one pop -> accept_ready=1 again.
REQ-038 fir_valid with no prior sample_accept -> credit_err=1 and stays 1 until rst_n=0.
REQ-039 rst_n pulsed low mid-stream with level=5 and inflight=2 -> out_valid=0, level=0, accept_ready=1 immediately; next push is delivered correctly.
